// File: rtl/kernel_bc_wb_pkg.sv
// Shared types and constants for the kernel_bc write-back burst engine.
package kernel_bc_wb_pkg;

    localparam int unsigned AXI_LEN_WIDTH = 8;

    typedef enum logic [2:0] {
        StIdle,
        StAw,
        StW,
        StB,
        StDone
    } wb_state_e;

    function automatic int unsigned bytes_per_beat(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/kernel_bc_write_back_burst.sv
// write_back stage of the kernel_bc dataflow region: drains num_items words per start
// token and writes them as AW/W/B bursts into a contiguous buffer at base_addr.
module kernel_bc_write_back_burst
    import kernel_bc_wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     start_empty_n,
    output logic                     start_read,
    input  logic [CNT_WIDTH-1:0]     num_items,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic [DATA_WIDTH-1:0]    in_dout,
    input  logic                     in_empty_n,
    output logic                     in_read,
    output logic                     aw_valid,
    input  logic                     aw_ready,
    output logic [ADDR_WIDTH-1:0]    aw_addr,
    output logic [AXI_LEN_WIDTH-1:0] aw_len,
    output logic                     w_valid,
    input  logic                     w_ready,
    output logic [DATA_WIDTH-1:0]    w_data,
    output logic                     w_last,
    input  logic                     b_valid,
    output logic                     b_ready,
    output logic                     ap_idle,
    output logic                     ap_done
);

    localparam logic [ADDR_WIDTH-1:0] BeatBytes = ADDR_WIDTH'(bytes_per_beat(DATA_WIDTH));
    localparam logic [CNT_WIDTH-1:0]  BurstMax  = CNT_WIDTH'(BURST_LEN);
    localparam logic [CNT_WIDTH-1:0]  CntOne    = CNT_WIDTH'(1);

    wb_state_e               state_q;
    logic [CNT_WIDTH-1:0]     remaining_q;
    logic [ADDR_WIDTH-1:0]    addr_q;
    logic [AXI_LEN_WIDTH-1:0] beat_q;

    logic [CNT_WIDTH-1:0]     burst;
    logic [CNT_WIDTH-1:0]     remaining_next;
    logic [AXI_LEN_WIDTH-1:0] last_beat;
    logic                     in_w;
    logic                     w_fire;

    // remaining_q only moves in B, so burst is stable across AW and W of one burst.
    always_comb begin
        burst          = (remaining_q > BurstMax) ? BurstMax : remaining_q;
        last_beat      = AXI_LEN_WIDTH'(burst - CntOne);
        remaining_next = remaining_q - burst;
    end

    assign ap_idle    = (state_q == StIdle);
    // A pop during reset would be lost, so hold the token FIFO off until reset releases.
    assign start_read = ap_idle && start_empty_n && ap_rst_n;
    assign aw_valid   = (state_q == StAw);
    assign aw_addr    = aw_valid ? addr_q : '0;
    assign aw_len     = aw_valid ? last_beat : '0;
    assign in_w       = (state_q == StW);
    assign w_valid    = in_w && in_empty_n;
    assign w_data     = in_w ? in_dout : '0;
    assign w_last     = in_w && (beat_q == last_beat);
    assign w_fire     = w_valid && w_ready;
    assign in_read    = w_fire;
    assign b_ready    = (state_q == StB);
    assign ap_done    = (state_q == StDone);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            addr_q      <= '0;
            beat_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_empty_n) begin
                        remaining_q <= num_items;
                        addr_q      <= base_addr;
                        state_q     <= (num_items == '0) ? StDone : StAw;
                    end
                end
                StAw: begin
                    if (aw_ready) begin
                        beat_q  <= '0;
                        state_q <= StW;
                    end
                end
                StW: begin
                    if (w_fire) begin
                        if (w_last) begin
                            state_q <= StB;
                        end else begin
                            beat_q <= beat_q + AXI_LEN_WIDTH'(1);
                        end
                    end
                end
                StB: begin
                    if (b_valid) begin
                        remaining_q <= remaining_next;
                        addr_q      <= addr_q + ADDR_WIDTH'(burst) * BeatBytes;
                        state_q     <= (remaining_next != '0) ? StAw : StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
